ppu_line_buf: RTL

Double-buffered scanline buffer between the PPU pixel renderer and the VGA output stage. The renderer writes one NES line (256 six-bit system palette indices) into the back bank while the VGA stage reads the front bank, which it indexes with its own NES coordinates. Banks swap at each NES line start. The block issues per-line render requests, replays the previous line on underrun, and tolerates the resolution doubler reading one line on two VGA lines.

---
 rtl/ppu_line_buf_if.sv | 25 ++
 rtl/ppu_line_buf.sv | 117 +++++++++++
 2 files changed

// File: rtl/ppu_line_buf_if.sv
// Renderer-write / VGA-read signal bundle for the scanline double buffer.
// The master side is the PPU/VGA environment; the slave side is the buffer.
interface ppu_line_buf_if;
  logic       wr_en_in;
  logic [5:0] wr_data_in;
  logic       wr_ready_out;
  logic [9:0] nes_x_in;
  logic [9:0] nes_y_in;
  logic [9:0] nes_y_next_in;
  logic       pix_pulse_in;
  logic [5:0] sys_palette_idx_out;
  logic       line_req_out;
  logic [7:0] line_num_out;
  logic       underrun_out;

  modport master (
    output wr_en_in, wr_data_in, nes_x_in, nes_y_in, nes_y_next_in, pix_pulse_in,
    input  wr_ready_out, sys_palette_idx_out, line_req_out, line_num_out, underrun_out
  );

  modport slave (
    input  wr_en_in, wr_data_in, nes_x_in, nes_y_in, nes_y_next_in, pix_pulse_in,
    output wr_ready_out, sys_palette_idx_out, line_req_out, line_num_out, underrun_out
  );
endinterface

// File: rtl/ppu_line_buf.sv
// Double-buffered 256x6 NES scanline buffer: renderer fills the back bank while
// the VGA stage reads the front bank; banks swap on each visible NES line start.
module ppu_line_buf (
  input logic           clk_in,
  input logic           rst_in,
  ppu_line_buf_if.slave bus
);

  logic [5:0] bank0_q [256];
  logic [5:0] bank1_q [256];

  logic [9:0] q_y_q;
  logic       rd_sel_q,   rd_sel_d;
  logic [7:0] wr_ptr_q,   wr_ptr_d;
  logic       full_q,     full_d;
  logic [5:0] idx_q,      idx_d;
  logic       req_q,      req_d;
  logic [7:0] num_q,      num_d;
  logic       underrun_q, underrun_d;

  logic       line_evt;
  logic       vis_evt;
  logic       pre_evt;
  logic       wr_acc;
  logic [7:0] rd_addr;
  logic [5:0] rd_data;
  logic       unused_x_hi;

  assign unused_x_hi = &{1'b0, bus.nes_x_in[9:8]};

  // A change of NES y fires once per NES line, even when the doubler repeats y.
  assign line_evt = (bus.nes_y_in != q_y_q);
  assign vis_evt  = line_evt && (bus.nes_y_in < 10'd240);
  assign pre_evt  = line_evt && (bus.nes_y_in >= 10'd240) && (bus.nes_y_next_in == '0);
  assign wr_acc   = bus.wr_en_in && !full_q && !vis_evt && !pre_evt;

  // Reading x+1 on the pulse makes the data valid when nes_x_in advances.
  assign rd_addr  = bus.nes_x_in[7:0] + 8'd1;
  assign rd_data  = rd_sel_q ? bank1_q[rd_addr] : bank0_q[rd_addr];

  always_comb begin
    rd_sel_d   = rd_sel_q;
    wr_ptr_d   = wr_ptr_q;
    full_d     = full_q;
    idx_d      = idx_q;
    req_d      = 1'b0;
    num_d      = num_q;
    underrun_d = underrun_q;

    if (bus.pix_pulse_in) begin
      idx_d = rd_data;
    end

    if (vis_evt) begin
      if (full_q) begin
        rd_sel_d = !rd_sel_q;
      end else begin
        underrun_d = 1'b1;
      end
      wr_ptr_d = '0;
      full_d   = 1'b0;
      if (bus.nes_y_in < 10'd239) begin
        req_d = 1'b1;
        num_d = bus.nes_y_in[7:0] + 8'd1;
      end
    end else if (pre_evt) begin
      wr_ptr_d = '0;
      full_d   = 1'b0;
      req_d    = 1'b1;
      num_d    = '0;
    end else if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 8'd1;
      if (wr_ptr_q == 8'hFF) begin
        full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      q_y_q      <= '0;
      rd_sel_q   <= 1'b0;
      wr_ptr_q   <= '0;
      full_q     <= 1'b0;
      idx_q      <= '0;
      req_q      <= 1'b0;
      num_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      q_y_q      <= bus.nes_y_in;
      rd_sel_q   <= rd_sel_d;
      wr_ptr_q   <= wr_ptr_d;
      full_q     <= full_d;
      idx_q      <= idx_d;
      req_q      <= req_d;
      num_q      <= num_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_acc) begin
      if (rd_sel_q) begin
        bank0_q[wr_ptr_q] <= bus.wr_data_in;
      end else begin
        bank1_q[wr_ptr_q] <= bus.wr_data_in;
      end
    end
  end

  assign bus.wr_ready_out        = !full_q;
  assign bus.sys_palette_idx_out = idx_q;
  assign bus.line_req_out        = req_q;
  assign bus.line_num_out        = num_q;
  assign bus.underrun_out        = underrun_q;

endmodule
